// File: rtl/spi_pkg.sv
// Shared types and limits for the SPI shift engine.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_WIDTH_DEFAULT = 8;
    localparam int SPI_WIDTH_MAX     = 32;

endpackage

// File: rtl/spi_bit_cnt.sv
// Bit counter for one SPI word: clear, increment and terminal-count at WIDTH-1.
module spi_bit_cnt #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (clr)
            bit_cnt <= '0;
        else if (inc)
            bit_cnt <= bit_cnt + 1'b1;
    end

    assign tc = (bit_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/spi_shift_duplex.sv
// Full-duplex SPI shift engine: loads a WIDTH-bit word, shifts it out while capturing s_in.
// Optional LSB-first support is enabled by defining SPI_SHIFT_LSB_FIRST_EN.
module spi_shift_duplex
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    input  logic             sample_en,
`ifdef SPI_SHIFT_LSB_FIRST_EN
    input  logic             lsb_first,
`endif
    input  logic             s_in,
    output logic             s_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    spi_state_e       state, state_nx;
    logic [WIDTH-1:0] tx_reg, rx_shift;
    logic [WIDTH-1:0] tx_shifted, rx_sampled;
    logic             tc, lsb_sel;
    logic             accept, complete, do_shift, do_sample;

`ifdef SPI_SHIFT_LSB_FIRST_EN
    logic lsb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lsb_q <= 1'b0;
        else if (accept)
            lsb_q <= lsb_first;
    end

    assign lsb_sel = lsb_q;
`else
    assign lsb_sel = 1'b0;
`endif

    spi_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept | complete),
        .inc   (do_sample),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = ACTIVE;
            ACTIVE:  if (sample_en && tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The completing sample wins over a coincident shift: tx_reg is cleared instead.
    always_comb begin
        busy      = (state == ACTIVE);
        accept    = (state == IDLE) && load;
        complete  = (state == ACTIVE) && sample_en && tc;
        do_shift  = (state == ACTIVE) && shift_en && !complete;
        do_sample = (state == ACTIVE) && sample_en;
    end

    always_comb begin
        if (lsb_sel) begin
            tx_shifted = tx_reg >> 1;
            rx_sampled = {s_in, rx_shift[WIDTH-1:1]};
        end else begin
            tx_shifted = {tx_reg[WIDTH-2:0], 1'b0};
            rx_sampled = {rx_shift[WIDTH-2:0], s_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            done     <= 1'b0;
        end else begin
            done <= complete;
            if (accept) begin
                tx_reg   <= data_in;
                rx_shift <= '0;
            end else if (complete) begin
                tx_reg  <= '0;
                rx_data <= rx_sampled;
            end else begin
                if (do_shift)  tx_reg   <= tx_shifted;
                if (do_sample) rx_shift <= rx_sampled;
            end
        end
    end

    assign s_out = lsb_sel ? tx_reg[0] : tx_reg[WIDTH-1];

endmodule

// File: tb/tb_spi_shift_duplex.sv
// Directed bench for spi_shift_duplex at WIDTH=8.
module tb_spi_shift_duplex;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         shift_en = 1'b0;
    logic         sample_en = 1'b0;
    logic         s_in = 1'b0;
    logic         s_out, busy, done;
    logic [W-1:0] rx_data;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    logic         lsb_first = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    spi_shift_duplex #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .shift_en  (shift_en),
        .sample_en (sample_en),
`ifdef SPI_SHIFT_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .s_in      (s_in),
        .s_out     (s_out),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [W-1:0] d);
        data_in = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic pair(input logic b);
        s_in      = b;
        shift_en  = 1'b1;
        sample_en = 1'b1;
        tick();
        shift_en  = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic [W-1:0] rx_exp);
        check({tag, "_s_out"}, 32'(s_out), 32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_rx"},    32'(rx_data), 32'(rx_exp));
    endtask

    initial begin
        logic [W-1:0] tx, rx;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            load      = 1'($urandom);
            data_in   = 8'($urandom);
            shift_en  = 1'($urandom);
            sample_en = 1'($urandom);
            s_in      = 1'($urandom);
            tick();
            check_idle($sformatf("rst%0d", i), 8'h00);
        end
        load = 0; shift_en = 0; sample_en = 0; s_in = 0; data_in = '0;
        rst_n = 1'b1;
        tick();

        // Basic transfer: tx 0xA5, rx 0x3C
        tx = 8'hA5; rx = 8'h3C;
        load_word(tx);
        check("basic_busy", 32'(busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            check($sformatf("basic_s_out_b%0d", i), 32'(s_out), 32'(tx[W-1-i]));
            check($sformatf("basic_done_b%0d", i), 32'(done), 32'd0);
            pair(rx[W-1-i]);
        end
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_rx", 32'(rx_data), 32'h3C);
        check("basic_s_out_end", 32'(s_out), 32'd0);
        tick();
        check("basic_done_clr", 32'(done), 32'd0);
        check("basic_rx_hold", 32'(rx_data), 32'h3C);

        // Load while busy is ignored
        load_word(8'hA5);
        for (int i = 0; i < 3; i++) pair(1'b1);
        load_word(8'hFF);
        check("lwb_busy", 32'(busy), 32'd1);
        tx = 8'hA5;
        for (int i = 3; i < W; i++) begin
            check($sformatf("lwb_s_out_b%0d", i), 32'(s_out), 32'(tx[W-1-i]));
            check($sformatf("lwb_done_b%0d", i), 32'(done), 32'd0);
            pair(1'b1);
        end
        check("lwb_done", 32'(done), 32'd1);
        check("lwb_rx", 32'(rx_data), 32'hFF);
        tick();
        check("lwb_done_once", 32'(done), 32'd0);

        // Reset mid-transfer
        load_word(8'hA5);
        for (int i = 0; i < 4; i++) pair(1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("mrst_async", 8'h00);
        tick();
        check_idle("mrst_hold", 8'h00);
        rst_n = 1'b1;
        tick();
        check("mrst_no_done", 32'(done), 32'd0);
        tx = 8'h81; rx = 8'hC3;
        load_word(tx);
        for (int i = 0; i < W; i++) begin
            check($sformatf("mrst_s_out_b%0d", i), 32'(s_out), 32'(tx[W-1-i]));
            pair(rx[W-1-i]);
        end
        check("mrst_done", 32'(done), 32'd1);
        check("mrst_rx", 32'(rx_data), 32'hC3);
        tick();

        // Strobes while idle do nothing
        for (int i = 0; i < 6; i++) begin
            pair(1'($urandom));
            check_idle($sformatf("idle%0d", i), 8'hC3);
        end

        // Back-to-back: load 0x55 in the done cycle of 0x96
        tx = 8'h96; rx = 8'h5A;
        load_word(tx);
        for (int i = 0; i < W; i++) pair(rx[W-1-i]);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_rx1", 32'(rx_data), 32'h5A);
        load_word(8'h55);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done1_clr", 32'(done), 32'd0);
        // Second word uses separated sample and shift strobes
        tx = 8'h55; rx = 8'hE7;
        for (int i = 0; i < W; i++) begin
            check($sformatf("b2b_s_out_b%0d", i), 32'(s_out), 32'(tx[W-1-i]));
            s_in = rx[W-1-i];
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            if (i < W - 1) begin
                check($sformatf("b2b_busy_b%0d", i), 32'(busy), 32'd1);
                shift_en = 1'b1;
                tick();
                shift_en = 1'b0;
            end
        end
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_busy_end", 32'(busy), 32'd0);
        check("b2b_rx2", 32'(rx_data), 32'hE7);
        check("b2b_s_out_end", 32'(s_out), 32'd0);
        tick();
        check("b2b_done2_clr", 32'(done), 32'd0);

`ifdef SPI_SHIFT_LSB_FIRST_EN
        // LSB-first: tx 0x0F, s_in 1 then zeros
        lsb_first = 1'b1;
        load_word(8'h0F);
        lsb_first = 1'b0;
        tx = 8'hF0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("lsb_s_out_b%0d", i), 32'(s_out), 32'(tx[W-1-i]));
            pair(i == 0);
        end
        check("lsb_done", 32'(done), 32'd1);
        check("lsb_rx", 32'(rx_data), 32'h01);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_shift_duplex.md
# spi_shift_duplex

Parametrised full-duplex SPI shift engine that replaces the fixed 8-bit transmit-only shifter. It loads a WIDTH-bit word, drives it serially while capturing the incoming serial stream, counts bits and reports completion. It sits between the SPI clock/strobe generator, which issues the sample_en/shift_en pulses, and the byte/word-level controller, which drives load/data_in and consumes rx_data/done. All logic runs on one system clock; SPI edges arrive as single-cycle strobes.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- CNT_W, $clog2(WIDTH+1), derived localparam, bit-counter width (not overridable)

- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  start request; accepted only when busy=0
- data_in  in  WIDTH  transmit word, captured on accepted load
- shift_en  in  1  one-cycle strobe at SPI shift edge
- sample_en  in  1  one-cycle strobe at SPI sample edge
- s_in  in  1  serial input (MISO/MOSI side, depending on master/slave use)
- s_out  out  1  serial output, current transmit bit
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- rx_data  out  WIDTH  last fully received word

## Operation
- States: IDLE, ACTIVE.
- IDLE: shift_en and sample_en are ignored. On load=1: tx_reg <= data_in, rx_shift <= 0, bit_cnt <= 0, busy <= 1, go to ACTIVE.
- ACTIVE: load is ignored, including in the completing cycle.
  - shift_en: tx_reg <= {tx_reg[WIDTH-2:0], 1'b0}.
  - sample_en: rx_shift <= {rx_shift[WIDTH-2:0], s_in}, bit_cnt <= bit_cnt+1.
- s_out = tx_reg[WIDTH-1], combinational from the register. Bit k appears on s_out after k accepted shift_en pulses.
- Completion: a sample_en while bit_cnt == WIDTH-1 triggers completion. At that edge:
  - rx_data <= {rx_shift[WIDTH-2:0], s_in}
  - tx_reg <= 0, so s_out idles at 0
  - bit_cnt <= 0, busy <= 0, done <= 1, go to IDLE
- shift_en coinciding with the completing sample is ignored. tx_reg is cleared.
- Simultaneous shift_en and sample_en in ACTIVE: both actions occur. Sampling uses the current s_in; the shift uses the pre-edge tx_reg.
- done is high for exactly one cycle, the cycle after the completing edge. It clears on the next edge unconditionally.
- rx_data holds its value until the next completion. It is not cleared by load.
- Reset asserted, including mid-transfer: all registers clear immediately and the state returns to IDLE. No done pulse is produced.

## Timing
- Reset values: s_out=0, busy=0, done=0, rx_data=0, bit_cnt=0, state=IDLE.
- Load latency: load sampled at edge n -> busy=1 and s_out=data_in[WIDTH-1] after edge n.
- Completion latency: the WIDTH-th sample_en sampled at edge m -> done=1, busy=0, rx_data valid after edge m.
- Back-to-back transfers: load may be asserted in the cycle where done=1 (busy=0). It is accepted, giving zero idle cycles between words.
- There is no minimum strobe spacing. Strobes on consecutive cycles are legal.

## Configuration
- SPI_SHIFT_LSB_FIRST_EN defined:
  - Adds input port lsb_first (1 bit), captured into a register on accepted load and held for the whole transfer.
  - When the captured value is 1: s_out = tx_reg[0]; shift is tx_reg >> 1; sampling is rx_shift <= {s_in, rx_shift[WIDTH-1:1]}; rx_data is completed the same way.
  - When the captured value is 0: MSB-first behaviour exactly as in Operation.
- SPI_SHIFT_LSB_FIRST_EN undefined: the port is absent and the block is MSB-first only.

## Structure
- Shared package spi_pkg holds:
  - the state enum typedef (IDLE, ACTIVE)
  - SPI_WIDTH_DEFAULT = 8
  - SPI_WIDTH_MAX = 32
- One sub-module, spi_bit_cnt: a parametrised CNT_W-bit counter with clear, increment and terminal-count (== WIDTH-1) outputs, instantiated once.
- All datapath registers and the FSM live in spi_shift_duplex.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 with random inputs -> s_out=0, busy=0, done=0, rx_data=0x00 throughout.
- Basic transfer: load 0xA5; 8 sample_en/shift_en pairs; s_in driven with 0x3C MSB-first -> s_out sequence 1,0,1,0,0,1,0,1; one-cycle done after the 8th sample; rx_data=0x3C; s_out=0 afterwards.
- Load while busy: after 3 bits, pulse load with data_in=0xFF -> ignored; remaining s_out bits 0,0,1,0,1 of 0xA5; a single done pulse.
- Reset mid-transfer: drop rst_n after 4 samples -> all outputs 0, no done pulse; a following load of 0x81 transfers normally with s_out 1,0,0,0,0,0,0,1.
- Idle strobes and back-to-back: strobes with no load -> no done, rx_data unchanged. Load 0x55 in the done cycle of a previous word -> accepted, busy stays 1, second done after 8 more samples.
- Macro build, SPI_SHIFT_LSB_FIRST_EN defined: lsb_first=1, load 0x0F, s_in sequence 1,0,0,0,0,0,0,0 -> s_out 1,1,1,1,0,0,0,0; rx_data=0x01.
